// File: rtl/dmem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl_if
// Bundles the core-side request/response signals and the data-memory
// signals of dmem_access_ctrl.
//   slave  : the controller (takes requests, drives the memory port)
//   master : the environment (core issuing requests + the memory model)
// Core side  : i_req, i_we, i_funct3, i_addr, i_wdata -> o_busy, o_ack,
//              o_err, o_rdata
// Memory side: o_mem_addr, o_mem_wd, o_mem_wen, o_mem_ren <- i_mem_rd
// ---------------------------------------------------------------------------
interface dmem_access_ctrl_if #(
  parameter int WORD_W = 32
);
  logic              i_req;
  logic              i_we;
  logic [2:0]        i_funct3;
  logic [WORD_W-1:0] i_addr;
  logic [WORD_W-1:0] i_wdata;
  logic              o_busy;
  logic              o_ack;
  logic              o_err;
  logic [WORD_W-1:0] o_rdata;
  logic [WORD_W-1:0] o_mem_addr;
  logic [WORD_W-1:0] o_mem_wd;
  logic [3:0]        o_mem_wen;
  logic              o_mem_ren;
  logic [WORD_W-1:0] i_mem_rd;

  modport slave (
    input  i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rd,
    output o_busy, o_ack, o_err, o_rdata,
    output o_mem_addr, o_mem_wd, o_mem_wen, o_mem_ren
  );

  modport master (
    output i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rd,
    input  o_busy, o_ack, o_err, o_rdata,
    input  o_mem_addr, o_mem_wd, o_mem_wen, o_mem_ren
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
// Sequences core loads/stores into a byte-enable data memory. Stores get
// lane-shifted data and byte enables (halfword stores at offset 1/2 are
// split into two byte writes); loads are aligned and sign/zero extended.
// Misaligned or illegal requests complete with o_err=1 and never touch
// memory.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : dmem_access_ctrl_if.slave (core request/response + memory port)
// All outputs, including the memory-side port, come straight from flops.
// ---------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int WORD_W = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  dmem_access_ctrl_if.slave       bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC1  = 3'd1,
    ACC2  = 3'd2,
    RWAIT = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t            state_q,  state_d;
  logic              we_q,     we_d;
  logic [2:0]        f3_q,     f3_d;
  logic [1:0]        off_q,    off_d;
  logic              split_q,  split_d;
  logic [3:0]        wen2_q,   wen2_d;
  logic              err_q,    err_d;
  logic [WORD_W-1:0] rdata_q,  rdata_d;
  logic [WORD_W-1:0] maddr_q,  maddr_d;
  logic [WORD_W-1:0] mwd_q,    mwd_d;
  logic [3:0]        mwen_q,   mwen_d;
  logic              mren_q,   mren_d;
  logic              busy_q,   busy_d;
  logic              ack_q,    ack_d;

  logic [1:0]        off_s;
  logic              illegal_s;
  logic              split_s;
  logic [3:0]        wen1_s;
  logic [3:0]        wen2_s;

  // Select the addressed byte/halfword from the memory word and extend it.
  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [31:0] lane;
    lane = word >> {off, 3'b000};
    case (f3)
      3'b000:  extend_load = {{24{lane[7]}}, lane[7:0]};
      3'b100:  extend_load = {24'd0, lane[7:0]};
      3'b001:  extend_load = {{16{lane[15]}}, lane[15:0]};
      3'b101:  extend_load = {16'd0, lane[15:0]};
      3'b010:  extend_load = word;
      default: extend_load = 32'd0;
    endcase
  endfunction

  // Decode the incoming request into legality and its write-enable pattern(s).
  always_comb begin
    off_s     = bus.i_addr[1:0];
    illegal_s = 1'b0;
    split_s   = 1'b0;
    wen1_s    = 4'b0000;
    wen2_s    = 4'b0000;
    case (bus.i_funct3)
      3'b000: wen1_s = 4'b0001 << off_s;
      3'b001: begin
        case (off_s)
          2'd0: wen1_s = 4'b0011;
          // The memory cannot write these lane pairs in one go: two byte writes.
          2'd1: begin
            wen1_s  = 4'b0010;
            wen2_s  = 4'b0100;
            split_s = 1'b1;
          end
          2'd2: begin
            wen1_s  = 4'b0100;
            wen2_s  = 4'b1000;
            split_s = 1'b1;
          end
          default: illegal_s = 1'b1;
        endcase
      end
      3'b010: begin
        if (off_s != 2'd0) begin
          illegal_s = 1'b1;
        end else begin
          wen1_s = 4'b1111;
        end
      end
      3'b100: begin
        if (bus.i_we) begin
          illegal_s = 1'b1;
        end else begin
          illegal_s = 1'b0;
        end
      end
      3'b101: begin
        if (bus.i_we || (off_s == 2'd3)) begin
          illegal_s = 1'b1;
        end else begin
          illegal_s = 1'b0;
        end
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // Next-state and next-output logic of the access sequencer.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    split_d = split_q;
    wen2_d  = wen2_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    maddr_d = maddr_q;
    mwd_d   = mwd_q;
    mwen_d  = 4'b0000;
    mren_d  = 1'b0;
    busy_d  = 1'b0;
    ack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_req) begin
          we_d    = bus.i_we;
          f3_d    = bus.i_funct3;
          off_d   = off_s;
          split_d = split_s;
          wen2_d  = wen2_s;
          err_d   = illegal_s;
          rdata_d = '0;
          maddr_d = bus.i_addr;
          mwd_d   = bus.i_wdata << {off_s, 3'b000};
          if (illegal_s) begin
            mwen_d = 4'b0000;
            mren_d = 1'b0;
          end else if (bus.i_we) begin
            mwen_d = wen1_s;
          end else begin
            mren_d = 1'b1;
          end
          // Illegal requests also pass through ACC1 (with no enables) so
          // that their ack lands one cycle after the accept cycle, the same
          // as a single-beat store.
          state_d = ACC1;
        end else begin
          state_d = IDLE;
        end
      end
      ACC1: begin
        if (err_q) begin
          state_d = RESP;
        end else if (we_q && split_q) begin
          mwen_d  = wen2_q;
          state_d = ACC2;
        end else if (we_q) begin
          state_d = RESP;
        end else begin
          state_d = RWAIT;
        end
      end
      ACC2: begin
        state_d = RESP;
      end
      RWAIT: begin
        rdata_d = extend_load(f3_q, off_q, bus.i_mem_rd);
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    ack_d  = (state_d == RESP);
  end

  // State and output registers; reset drops every output to zero at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      split_q <= 1'b0;
      wen2_q  <= 4'b0000;
      err_q   <= 1'b0;
      rdata_q <= '0;
      maddr_q <= '0;
      mwd_q   <= '0;
      mwen_q  <= 4'b0000;
      mren_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      split_q <= split_d;
      wen2_q  <= wen2_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      maddr_q <= maddr_d;
      mwd_q   <= mwd_d;
      mwen_q  <= mwen_d;
      mren_q  <= mren_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.o_busy     = busy_q;
  assign bus.o_ack      = ack_q;
  assign bus.o_err      = err_q;
  assign bus.o_rdata    = rdata_q;
  assign bus.o_mem_addr = maddr_q;
  assign bus.o_mem_wd   = mwd_q;
  assign bus.o_mem_wen  = mwen_q;
  assign bus.o_mem_ren  = mren_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_ctrl
// Drives load/store requests into dmem_access_ctrl, attaches a word memory
// with registered read data, and checks every transaction against a
// byte-addressed reference memory and the access rules (enable sequence,
// lane data, ack latency, error flag, extended load data).
// ---------------------------------------------------------------------------
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dmem_access_ctrl_if #(.WORD_W(32)) bif ();

  dmem_access_ctrl #(.WORD_W(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Byte-addressed reference memory (256 bytes, little endian).
  logic [7:0] ref_mem [0:255];

  // Word memory attached to the DUT; read data appears the cycle after ren.
  logic [31:0] mem_w [0:63];
  logic [31:0] mem_rd_q = 32'd0;
  bit          seeded   = 1'b0;

  function automatic logic [7:0] seed_byte(input int i);
    return 8'((i * 37 + 11) ^ ((i >> 3) * 91));
  endfunction

  always @(posedge clk) begin
    if (!seeded) begin
      for (int w = 0; w < 64; w++)
        mem_w[w] = {seed_byte(4*w+3), seed_byte(4*w+2), seed_byte(4*w+1), seed_byte(4*w)};
      seeded = 1'b1;
    end
    if (bif.o_mem_ren) mem_rd_q <= mem_w[bif.o_mem_addr[7:2]];
    for (int n = 0; n < 4; n++)
      if (bif.o_mem_wen[n]) mem_w[bif.o_mem_addr[7:2]][8*n +: 8] = bif.o_mem_wd[8*n +: 8];
  end

  assign bif.i_mem_rd = mem_rd_q;

  // One complete access, checked against the reference rules.
  task automatic do_access(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input bit noise, output logic [31:0] got_rd);
    logic [1:0]  off;
    logic [7:0]  a;
    bit          illegal;
    logic [3:0]  exp_wen [$];
    logic [3:0]  got_wen [$];
    int          exp_k, ack_at, ren_cyc, exp_ren;
    logic        got_err;
    logic [31:0] exp_rd, exp_wd;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    bit          busy_bad, wd_bad, both_bad, addr_bad, seq_bad;

    off = addr[1:0];
    a   = addr[7:0];
    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
              (we && (f3 == 3'b100 || f3 == 3'b101)) ||
              (f3 == 3'b010 && off != 2'd0) ||
              ((f3 == 3'b001 || f3 == 3'b101) && off == 2'd3);
    exp_wd = wdata << (32'd8 * 32'(off));
    b = ref_mem[a];
    h = {ref_mem[a + 8'd1], ref_mem[a]};
    w = {ref_mem[{a[7:2], 2'd3}], ref_mem[{a[7:2], 2'd2}], ref_mem[{a[7:2], 2'd1}], ref_mem[{a[7:2], 2'd0}]};
    case (f3)
      3'b000:  exp_rd = {{24{b[7]}}, b};
      3'b100:  exp_rd = {24'd0, b};
      3'b001:  exp_rd = {{16{h[15]}}, h};
      3'b101:  exp_rd = {16'd0, h};
      3'b010:  exp_rd = w;
      default: exp_rd = 32'd0;
    endcase
    if (!illegal && we) begin
      if (f3 == 3'b000)                   exp_wen.push_back(4'b0001 << off);
      else if (f3 == 3'b010)              exp_wen.push_back(4'b1111);
      else if (off == 2'd0)               exp_wen.push_back(4'b0011);
      else begin
        exp_wen.push_back(4'b0001 << off);
        exp_wen.push_back(4'b0010 << off);
      end
    end
    exp_ren = (!illegal && !we) ? 1 : 0;
    exp_k   = illegal ? 2 : (we ? 1 + exp_wen.size() : 3);

    @(negedge clk);
    bif.i_req = 1'b1; bif.i_we = we; bif.i_funct3 = f3; bif.i_addr = addr; bif.i_wdata = wdata;
    @(posedge clk);
    ack_at = 0; ren_cyc = 0; got_err = 1'bx; got_rd = 32'hxxxx_xxxx;
    busy_bad = 1'b0; wd_bad = 1'b0; both_bad = 1'b0; addr_bad = 1'b0;
    for (int c = 1; c <= 8 && ack_at == 0; c++) begin
      @(negedge clk);
      if (bif.o_busy !== 1'b1) busy_bad = 1'b1;
      if (bif.o_mem_wen != 4'b0000) begin
        got_wen.push_back(bif.o_mem_wen);
        if (bif.o_mem_wd !== exp_wd) wd_bad = 1'b1;
        if (bif.o_mem_addr !== addr) addr_bad = 1'b1;
      end
      if (bif.o_mem_ren) begin
        ren_cyc++;
        if (bif.o_mem_addr !== addr) addr_bad = 1'b1;
      end
      if (bif.o_mem_wen != 4'b0000 && bif.o_mem_ren) both_bad = 1'b1;
      if (bif.o_ack === 1'b1) begin
        ack_at = c; got_err = bif.o_err; got_rd = bif.o_rdata; bif.i_req = 1'b0;
      end else if (noise) begin
        bif.i_req = 1'b1; bif.i_we = 1'($urandom_range(0, 1)); bif.i_funct3 = 3'($urandom);
        bif.i_addr = $urandom; bif.i_wdata = $urandom;
      end else begin
        bif.i_req = 1'b0;
      end
    end
    bif.i_req = 1'b0;

    seq_bad = (got_wen.size() != exp_wen.size());
    if (!seq_bad) for (int i = 0; i < exp_wen.size(); i++) if (got_wen[i] !== exp_wen[i]) seq_bad = 1'b1;

    n_checks++; if (ack_at !== exp_k) $display("FAIL %s ack_cycle: got %0d expected %0d", tag, ack_at, exp_k); else n_pass++;
    n_checks++; if (got_err !== illegal) $display("FAIL %s err: got %b expected %b", tag, got_err, illegal); else n_pass++;
    n_checks++; if (seq_bad) $display("FAIL %s wen_seq: got %p expected %p", tag, got_wen, exp_wen); else n_pass++;
    n_checks++; if (ren_cyc !== exp_ren) $display("FAIL %s ren_cycles: got %0d expected %0d", tag, ren_cyc, exp_ren); else n_pass++;
    n_checks++; if (wd_bad || addr_bad || both_bad || busy_bad)
      $display("FAIL %s bus: wd_bad=%b addr_bad=%b both_bad=%b busy_bad=%b expected all 0", tag, wd_bad, addr_bad, both_bad, busy_bad);
    else n_pass++;
    if (exp_ren == 1) begin
      n_checks++; if (got_rd !== exp_rd) $display("FAIL %s rdata: got %h expected %h", tag, got_rd, exp_rd); else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (bif.o_ack !== 1'b0 || bif.o_busy !== 1'b0 || bif.o_err !== got_err || bif.o_rdata !== got_rd)
      $display("FAIL %s after_ack: ack=%b busy=%b err=%b rdata=%h expected ack=0 busy=0 err=%b rdata=%h",
               tag, bif.o_ack, bif.o_busy, bif.o_err, bif.o_rdata, got_err, got_rd);
    else n_pass++;

    if (!illegal && we) begin
      ref_mem[a] = wdata[7:0];
      if (f3 != 3'b000) ref_mem[a + 8'd1] = wdata[15:8];
      if (f3 == 3'b010) begin
        ref_mem[a + 8'd2] = wdata[23:16];
        ref_mem[a + 8'd3] = wdata[31:24];
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bif.o_busy, bif.o_ack, bif.o_err, bif.o_mem_ren, bif.o_mem_wen} !== 8'd0 ||
        bif.o_rdata !== 32'd0 || bif.o_mem_addr !== 32'd0 || bif.o_mem_wd !== 32'd0)
      $display("FAIL reset_outputs: busy=%b ack=%b err=%b ren=%b wen=%b rdata=%h addr=%h wd=%h expected all 0",
               bif.o_busy, bif.o_ack, bif.o_err, bif.o_mem_ren, bif.o_mem_wen, bif.o_rdata, bif.o_mem_addr, bif.o_mem_wd);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bif.o_busy !== 1'b0) $display("FAIL idle_after_reset: busy got %b expected 0", bif.o_busy); else n_pass++;
  endtask

  task automatic test_word_and_byte();
    logic [31:0] rd;
    do_access("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, rd);
    do_access("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd);
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL plan_lw_10: got %h expected deadbeef", rd); else n_pass++;
    do_access("sb_13", 1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b0, rd);
    do_access("lb_13", 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, rd);
    n_checks++; if (rd !== 32'hFFFFFFA5) $display("FAIL plan_lb_13: got %h expected ffffffa5", rd); else n_pass++;
    do_access("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, rd);
    n_checks++; if (rd !== 32'h000000A5) $display("FAIL plan_lbu_13: got %h expected 000000a5", rd); else n_pass++;
  endtask

  task automatic test_split_store();
    logic [31:0] rd;
    do_access("sh_22", 1'b1, 3'b001, 32'h22, 32'h00008123, 1'b0, rd);
    do_access("lh_22", 1'b0, 3'b001, 32'h22, 32'h0, 1'b0, rd);
    n_checks++; if (rd !== 32'hFFFF8123) $display("FAIL plan_lh_22: got %h expected ffff8123", rd); else n_pass++;
    do_access("lhu_22", 1'b0, 3'b101, 32'h22, 32'h0, 1'b0, rd);
    n_checks++; if (rd !== 32'h00008123) $display("FAIL plan_lhu_22: got %h expected 00008123", rd); else n_pass++;
    do_access("sw_30", 1'b1, 3'b010, 32'h30, 32'h11111111, 1'b0, rd);
    do_access("sh_31", 1'b1, 3'b001, 32'h31, 32'h00007F01, 1'b0, rd);
    do_access("lw_30", 1'b0, 3'b010, 32'h30, 32'h0, 1'b0, rd);
    n_checks++; if (rd !== 32'h117F0111) $display("FAIL plan_lw_30: got %h expected 117f0111", rd); else n_pass++;
  endtask

  task automatic test_illegal();
    logic [31:0] rd;
    do_access("lw_06_misaligned", 1'b0, 3'b010, 32'h06, 32'h0, 1'b0, rd);
    do_access("sh_07_misaligned", 1'b1, 3'b001, 32'h07, 32'h1234, 1'b0, rd);
    do_access("funct3_011", 1'b0, 3'b011, 32'h08, 32'h0, 1'b0, rd);
    do_access("sbu_store", 1'b1, 3'b100, 32'h09, 32'h55, 1'b0, rd);
  endtask

  task automatic test_reset_mid_split();
    logic [31:0] rd;
    @(negedge clk);
    bif.i_req = 1'b1; bif.i_we = 1'b1; bif.i_funct3 = 3'b001; bif.i_addr = 32'h22; bif.i_wdata = 32'h0000C3B4;
    @(posedge clk);
    @(negedge clk);
    bif.i_req = 1'b0;
    n_checks++; if (bif.o_mem_wen !== 4'b0100) $display("FAIL split_first_beat: got %b expected 0100", bif.o_mem_wen); else n_pass++;
    @(posedge clk);
    #2;
    n_checks++; if (bif.o_mem_wen !== 4'b1000) $display("FAIL split_second_beat: got %b expected 1000", bif.o_mem_wen); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bif.o_busy, bif.o_ack, bif.o_err, bif.o_mem_ren, bif.o_mem_wen} !== 8'd0 || bif.o_mem_wd !== 32'd0 || bif.o_mem_addr !== 32'd0)
      $display("FAIL reset_mid_split: busy=%b ack=%b wen=%b ren=%b wd=%h expected all 0",
               bif.o_busy, bif.o_ack, bif.o_mem_wen, bif.o_mem_ren, bif.o_mem_wd);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_mem[8'h22] = 8'hB4;
    begin
      bit saw_ack = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (bif.o_ack !== 1'b0) saw_ack = 1'b1;
      end
      n_checks++; if (saw_ack) $display("FAIL no_ack_after_reset: got ack expected none"); else n_pass++;
    end
    do_access("lw_20_after_reset", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, rd);
    n_checks++; if (rd[23:16] !== 8'hB4) $display("FAIL lane2_written: got %h expected b4", rd[23:16]); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rd;
    for (int i = 0; i < 200; i++)
      do_access("random", 1'($urandom_range(0, 1)), 3'($urandom), 32'($urandom_range(0, 255)),
                $urandom, 1'($urandom_range(0, 1)), rd);
  endtask

  initial begin
    bif.i_req = 1'b0; bif.i_we = 1'b0; bif.i_funct3 = 3'b000; bif.i_addr = 32'd0; bif.i_wdata = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_byte(i);
    test_reset();
    test_word_and_byte();
    test_split_store();
    test_illegal();
    test_reset_mid_split();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
